// File: rtl/id_stage_pkg.sv
// rtl/id_stage_pkg.sv - RV32I opcode/ALU encodings and ID/EX register layout
package id_stage_pkg;

  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  localparam logic [3:0] ALU_ADD    = 4'd0;
  localparam logic [3:0] ALU_SUB    = 4'd1;
  localparam logic [3:0] ALU_SLL    = 4'd2;
  localparam logic [3:0] ALU_SLT    = 4'd3;
  localparam logic [3:0] ALU_SLTU   = 4'd4;
  localparam logic [3:0] ALU_XOR    = 4'd5;
  localparam logic [3:0] ALU_SRL    = 4'd6;
  localparam logic [3:0] ALU_SRA    = 4'd7;
  localparam logic [3:0] ALU_OR     = 4'd8;
  localparam logic [3:0] ALU_AND    = 4'd9;
  localparam logic [3:0] ALU_PASS_B = 4'd10;

  localparam logic [6:0] FUNCT7_BASE = 7'b0000000;
  localparam logic [6:0] FUNCT7_ALT  = 7'b0100000;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] imm;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [4:0]  rd;
    logic [3:0]  alu_op;
    logic        alu_src_imm;
    logic [2:0]  funct3;
    logic        mem_read;
    logic        mem_write;
    logic        reg_write;
    logic        branch;
    logic        jal;
    logic        jalr;
    logic        lui;
    logic        auipc;
    logic        illegal;
  } id_ex_t;

  function automatic logic rs1_used(input logic [6:0] opc);
    return !(opc == OPC_LUI || opc == OPC_AUIPC || opc == OPC_JAL);
  endfunction

  function automatic logic rs2_used(input logic [6:0] opc);
    return (opc == OPC_OP || opc == OPC_STORE || opc == OPC_BRANCH);
  endfunction

endpackage

// File: rtl/id_stage_imm_gen.sv
// rtl/id_stage_imm_gen.sv - combinational RV32I immediate generator
module imm_gen
  import id_stage_pkg::*;
(
  input  logic [31:0] instr,
  output logic [31:0] imm
);

  always_comb begin
    imm = {{20{instr[31]}}, instr[31:20]};
    case (instr[6:0])
      OPC_STORE:  imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      OPC_BRANCH: imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      OPC_JAL:    imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      OPC_LUI,
      OPC_AUIPC:  imm = {instr[31:12], 12'b0};
      default:    imm = {{20{instr[31]}}, instr[31:20]};
    endcase
  end

endmodule

// File: rtl/id_stage.sv
// rtl/id_stage.sv - RV32I decode stage with WB bypass, load-use stall and ID/EX register
module id_stage
  import id_stage_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_valid,
  input  logic [31:0]     if_instr,
  input  logic [XLEN-1:0] if_pc,
  input  logic            flush,
  output logic [4:0]      rg_sr1_addr,
  output logic [4:0]      rg_sr2_addr,
  input  logic [XLEN-1:0] rg_sr1_data,
  input  logic [XLEN-1:0] rg_sr2_data,
  input  logic            wb_we,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic            id_stall,
  output logic            ex_valid,
  output logic [XLEN-1:0] ex_pc,
  output logic [XLEN-1:0] ex_rs1_data,
  output logic [XLEN-1:0] ex_rs2_data,
  output logic [XLEN-1:0] ex_imm,
  output logic [4:0]      ex_rs1_addr,
  output logic [4:0]      ex_rs2_addr,
  output logic [4:0]      ex_rd,
  output logic [3:0]      ex_alu_op,
  output logic            ex_alu_src_imm,
  output logic [2:0]      ex_funct3,
  output logic            ex_mem_read,
  output logic            ex_mem_write,
  output logic            ex_reg_write,
  output logic            ex_branch,
  output logic            ex_jal,
  output logic            ex_jalr,
  output logic            ex_lui,
  output logic            ex_auipc,
  output logic            ex_illegal
);

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [4:0]  rd;
  logic [31:0] imm;
  logic        load_use;
  id_ex_t      d;
  id_ex_t      q;

  assign opcode = if_instr[6:0];
  assign funct3 = if_instr[14:12];
  assign funct7 = if_instr[31:25];
  assign rs1    = if_instr[19:15];
  assign rs2    = if_instr[24:20];
  assign rd     = if_instr[11:7];

  assign rg_sr1_addr = rs1;
  assign rg_sr2_addr = rs2;

  imm_gen u_imm_gen (
    .instr (if_instr),
    .imm   (imm)
  );

  always_comb begin
    d             = '0;
    d.valid       = if_valid;
    d.pc          = if_pc;
    d.imm         = imm;
    d.rs1_addr    = rs1;
    d.rs2_addr    = rs2;
    d.rd          = rd;
    d.funct3      = funct3;
    d.alu_op      = ALU_ADD;
    // The register file writes at the same edge that samples ID/EX, so WB must be bypassed here.
    d.rs1_data    = (wb_we && wb_rd != 5'd0 && wb_rd == rs1) ? wb_data : rg_sr1_data;
    d.rs2_data    = (wb_we && wb_rd != 5'd0 && wb_rd == rs2) ? wb_data : rg_sr2_data;

    case (opcode)
      OPC_OP: begin
        d.reg_write = 1'b1;
        if (funct7 == FUNCT7_BASE) begin
          case (funct3)
            3'b000:  d.alu_op = ALU_ADD;
            3'b001:  d.alu_op = ALU_SLL;
            3'b010:  d.alu_op = ALU_SLT;
            3'b011:  d.alu_op = ALU_SLTU;
            3'b100:  d.alu_op = ALU_XOR;
            3'b101:  d.alu_op = ALU_SRL;
            3'b110:  d.alu_op = ALU_OR;
            default: d.alu_op = ALU_AND;
          endcase
        end else if (funct7 == FUNCT7_ALT && funct3 == 3'b000) begin
          d.alu_op = ALU_SUB;
        end else if (funct7 == FUNCT7_ALT && funct3 == 3'b101) begin
          d.alu_op = ALU_SRA;
        end else begin
          d.illegal = 1'b1;
        end
      end
      OPC_OP_IMM: begin
        d.reg_write   = 1'b1;
        d.alu_src_imm = 1'b1;
        case (funct3)
          3'b000: d.alu_op = ALU_ADD;
          3'b010: d.alu_op = ALU_SLT;
          3'b011: d.alu_op = ALU_SLTU;
          3'b100: d.alu_op = ALU_XOR;
          3'b110: d.alu_op = ALU_OR;
          3'b111: d.alu_op = ALU_AND;
          3'b001: begin
            d.alu_op  = ALU_SLL;
            d.illegal = (funct7 != FUNCT7_BASE);
          end
          default: begin
            if (funct7 == FUNCT7_BASE)     d.alu_op = ALU_SRL;
            else if (funct7 == FUNCT7_ALT) d.alu_op = ALU_SRA;
            else                           d.illegal = 1'b1;
          end
        endcase
      end
      OPC_LOAD: begin
        d.mem_read    = 1'b1;
        d.reg_write   = 1'b1;
        d.alu_src_imm = 1'b1;
      end
      OPC_STORE: begin
        d.mem_write   = 1'b1;
        d.alu_src_imm = 1'b1;
      end
      OPC_BRANCH: begin
        d.branch = 1'b1;
        d.alu_op = ALU_SUB;
      end
      OPC_JAL: begin
        d.jal       = 1'b1;
        d.reg_write = 1'b1;
      end
      OPC_JALR: begin
        d.jalr        = 1'b1;
        d.reg_write   = 1'b1;
        d.alu_src_imm = 1'b1;
      end
      OPC_LUI: begin
        d.lui         = 1'b1;
        d.reg_write   = 1'b1;
        d.alu_src_imm = 1'b1;
        d.alu_op      = ALU_PASS_B;
      end
      OPC_AUIPC: begin
        d.auipc       = 1'b1;
        d.reg_write   = 1'b1;
        d.alu_src_imm = 1'b1;
      end
      OPC_MISC_MEM: ;
      default: d.illegal = 1'b1;
    endcase

    if (d.illegal) begin
      d.reg_write = 1'b0;
      d.mem_read  = 1'b0;
      d.mem_write = 1'b0;
    end
    if (rd == 5'd0) d.reg_write = 1'b0;
  end

  assign load_use = if_valid && q.valid && q.mem_read && (q.rd != 5'd0) &&
                    ((rs1_used(opcode) && rs1 == q.rd) || (rs2_used(opcode) && rs2 == q.rd));

  assign id_stall = load_use && !flush;

  // Reset, flush and load-use bubbles all clear the whole register.
  always_ff @(posedge clk) begin
    if (rst || flush || load_use) q <= '0;
    else                          q <= d;
  end

  assign ex_valid       = q.valid;
  assign ex_pc          = q.pc;
  assign ex_rs1_data    = q.rs1_data;
  assign ex_rs2_data    = q.rs2_data;
  assign ex_imm         = q.imm;
  assign ex_rs1_addr    = q.rs1_addr;
  assign ex_rs2_addr    = q.rs2_addr;
  assign ex_rd          = q.rd;
  assign ex_alu_op      = q.alu_op;
  assign ex_alu_src_imm = q.alu_src_imm;
  assign ex_funct3      = q.funct3;
  assign ex_mem_read    = q.mem_read;
  assign ex_mem_write   = q.mem_write;
  assign ex_reg_write   = q.reg_write;
  assign ex_branch      = q.branch;
  assign ex_jal         = q.jal;
  assign ex_jalr        = q.jalr;
  assign ex_lui         = q.lui;
  assign ex_auipc       = q.auipc;
  assign ex_illegal     = q.illegal;

endmodule

// File: tb/tb_id_stage.sv
// tb/tb_id_stage.sv - directed self-checking bench for id_stage
module tb_id_stage;

  logic        clk;
  logic        rst;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        flush;
  logic [4:0]  rg_sr1_addr;
  logic [4:0]  rg_sr2_addr;
  logic [31:0] rg_sr1_data;
  logic [31:0] rg_sr2_data;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        id_stall;
  logic        ex_valid;
  logic [31:0] ex_pc;
  logic [31:0] ex_rs1_data;
  logic [31:0] ex_rs2_data;
  logic [31:0] ex_imm;
  logic [4:0]  ex_rs1_addr;
  logic [4:0]  ex_rs2_addr;
  logic [4:0]  ex_rd;
  logic [3:0]  ex_alu_op;
  logic        ex_alu_src_imm;
  logic [2:0]  ex_funct3;
  logic        ex_mem_read;
  logic        ex_mem_write;
  logic        ex_reg_write;
  logic        ex_branch;
  logic        ex_jal;
  logic        ex_jalr;
  logic        ex_lui;
  logic        ex_auipc;
  logic        ex_illegal;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [31:0] ADDI_X1_5    = 32'h00500093;
  localparam logic [31:0] ADD_X3_X1_X2 = 32'h002081B3;
  localparam logic [31:0] LW_X5_0_X2   = 32'h00012283;
  localparam logic [31:0] ADD_X6_X5_X7 = 32'h00728333;
  localparam logic [31:0] LUI_X6_28    = 32'h00028337;
  localparam logic [31:0] BEQ_X1_X2_8  = 32'h00208463;
  localparam logic [31:0] JAL_X1_M4    = 32'hFFDFF0EF;
  localparam logic [31:0] SW_X2_M1_X1  = 32'hFE20AFA3;
  localparam logic [31:0] LUI_X1_ABCDE = 32'hABCDE0B7;
  localparam logic [31:0] BAD_OPCODE   = 32'h0000007F;
  localparam logic [31:0] MUL_X3_X1_X2 = 32'h022081B3;
  localparam logic [31:0] ADD_X0_X1_X2 = 32'h00208033;
  localparam logic [31:0] ECALL        = 32'h00000073;
  localparam logic [31:0] FENCE        = 32'h0000000F;

  id_stage dut (
    .clk            (clk),
    .rst            (rst),
    .if_valid       (if_valid),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .flush          (flush),
    .rg_sr1_addr    (rg_sr1_addr),
    .rg_sr2_addr    (rg_sr2_addr),
    .rg_sr1_data    (rg_sr1_data),
    .rg_sr2_data    (rg_sr2_data),
    .wb_we          (wb_we),
    .wb_rd          (wb_rd),
    .wb_data        (wb_data),
    .id_stall       (id_stall),
    .ex_valid       (ex_valid),
    .ex_pc          (ex_pc),
    .ex_rs1_data    (ex_rs1_data),
    .ex_rs2_data    (ex_rs2_data),
    .ex_imm         (ex_imm),
    .ex_rs1_addr    (ex_rs1_addr),
    .ex_rs2_addr    (ex_rs2_addr),
    .ex_rd          (ex_rd),
    .ex_alu_op      (ex_alu_op),
    .ex_alu_src_imm (ex_alu_src_imm),
    .ex_funct3      (ex_funct3),
    .ex_mem_read    (ex_mem_read),
    .ex_mem_write   (ex_mem_write),
    .ex_reg_write   (ex_reg_write),
    .ex_branch      (ex_branch),
    .ex_jal         (ex_jal),
    .ex_jalr        (ex_jalr),
    .ex_lui         (ex_lui),
    .ex_auipc       (ex_auipc),
    .ex_illegal     (ex_illegal)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst         = 1'b1;
    if_valid    = 1'b1;
    if_instr    = ADDI_X1_5;
    if_pc       = 32'h0000_1000;
    flush       = 1'b0;
    rg_sr1_data = 32'h0;
    rg_sr2_data = 32'h0;
    wb_we       = 1'b0;
    wb_rd       = 5'd0;
    wb_data     = 32'h0;

    tick();
    tick();
    check("reset_valid", ex_valid, 0);
    check("reset_imm", ex_imm, 0);
    check("reset_rd", ex_rd, 0);
    check("reset_reg_write", ex_reg_write, 0);
    check("reset_pc", ex_pc, 0);
    check("reset_stall", id_stall, 0);

    rst = 1'b0;
    tick();
    check("addi_valid", ex_valid, 1);
    check("addi_imm", ex_imm, 5);
    check("addi_rd", ex_rd, 1);
    check("addi_alu_op", ex_alu_op, 0);
    check("addi_src_imm", ex_alu_src_imm, 1);
    check("addi_reg_write", ex_reg_write, 1);
    check("addi_pc", ex_pc, 32'h0000_1000);

    if_instr    = ADD_X3_X1_X2;
    if_pc       = 32'h0000_1004;
    wb_we       = 1'b1;
    wb_rd       = 5'd1;
    wb_data     = 32'hDEADBEEF;
    rg_sr1_data = 32'h0;
    rg_sr2_data = 32'h22;
    #1;
    check("sr1_addr", rg_sr1_addr, 1);
    check("sr2_addr", rg_sr2_addr, 2);
    tick();
    check("bypass_rs1", ex_rs1_data, 32'hDEADBEEF);
    check("bypass_rs2_untouched", ex_rs2_data, 32'h22);
    check("add_rd", ex_rd, 3);
    check("add_src_imm", ex_alu_src_imm, 0);

    wb_rd = 5'd0;
    tick();
    check("no_bypass_x0", ex_rs1_data, 0);

    wb_rd = 5'd2;
    tick();
    check("bypass_rs2", ex_rs2_data, 32'hDEADBEEF);
    check("bypass_rs1_off", ex_rs1_data, 0);
    wb_we = 1'b0;

    if_instr = LW_X5_0_X2;
    #1;
    check("lw_no_stall", id_stall, 0);
    tick();
    check("lw_mem_read", ex_mem_read, 1);
    check("lw_rd", ex_rd, 5);
    if_instr = ADD_X6_X5_X7;
    #1;
    check("load_use_stall", id_stall, 1);
    tick();
    check("bubble_valid", ex_valid, 0);
    check("bubble_mem_read", ex_mem_read, 0);
    check("stall_released", id_stall, 0);
    tick();
    check("dep_add_valid", ex_valid, 1);
    check("dep_add_rd", ex_rd, 6);
    check("dep_add_rs1", ex_rs1_addr, 5);
    check("dep_add_rs2", ex_rs2_addr, 7);

    if_instr = LW_X5_0_X2;
    tick();
    if_instr = LUI_X6_28;
    #1;
    check("lui_no_stall", id_stall, 0);
    tick();
    check("lui_valid", ex_valid, 1);
    check("lui_flag", ex_lui, 1);
    check("lui_imm", ex_imm, 32'h00028000);
    check("lui_alu_op", ex_alu_op, 10);

    if_instr = BEQ_X1_X2_8;
    flush    = 1'b1;
    tick();
    check("flush_valid", ex_valid, 0);
    check("flush_branch", ex_branch, 0);
    flush = 1'b0;

    if_instr = LW_X5_0_X2;
    tick();
    if_instr = ADD_X6_X5_X7;
    flush    = 1'b1;
    #1;
    check("flush_beats_stall", id_stall, 0);
    tick();
    check("flush_lu_bubble", ex_valid, 0);
    flush = 1'b0;
    #1;
    check("after_flush_no_stall", id_stall, 0);
    tick();
    check("after_flush_valid", ex_valid, 1);
    check("after_flush_rd", ex_rd, 6);

    if_instr = BEQ_X1_X2_8;
    tick();
    check("beq_imm", ex_imm, 8);
    check("beq_branch", ex_branch, 1);
    check("beq_reg_write", ex_reg_write, 0);

    if_instr = JAL_X1_M4;
    tick();
    check("jal_imm", ex_imm, 32'hFFFFFFFC);
    check("jal_flag", ex_jal, 1);
    check("jal_reg_write", ex_reg_write, 1);

    if_instr = SW_X2_M1_X1;
    tick();
    check("sw_imm", ex_imm, 32'hFFFFFFFF);
    check("sw_mem_write", ex_mem_write, 1);
    check("sw_reg_write", ex_reg_write, 0);
    check("sw_funct3", ex_funct3, 2);

    if_instr = LUI_X1_ABCDE;
    tick();
    check("lui_u_imm", ex_imm, 32'hABCDE000);

    if_instr = BAD_OPCODE;
    tick();
    check("bad_opc_illegal", ex_illegal, 1);
    check("bad_opc_reg_write", ex_reg_write, 0);
    check("bad_opc_valid", ex_valid, 1);

    if_instr = MUL_X3_X1_X2;
    tick();
    check("funct7_illegal", ex_illegal, 1);
    check("funct7_reg_write", ex_reg_write, 0);
    check("funct7_valid", ex_valid, 1);

    if_instr = ADD_X0_X1_X2;
    tick();
    check("rd0_reg_write", ex_reg_write, 0);
    check("rd0_legal", ex_illegal, 0);

    if_instr = ECALL;
    tick();
    check("ecall_illegal", ex_illegal, 1);

    if_instr = FENCE;
    tick();
    check("fence_legal", ex_illegal, 0);
    check("fence_valid", ex_valid, 1);
    check("fence_reg_write", ex_reg_write, 0);

    if_instr = LW_X5_0_X2;
    tick();
    if_instr = ADD_X6_X5_X7;
    #1;
    check("pre_reset_stall", id_stall, 1);
    rst = 1'b1;
    tick();
    check("mid_stall_reset_valid", ex_valid, 0);
    check("mid_stall_reset_stall", id_stall, 0);
    rst = 1'b0;
    tick();
    check("post_reset_issue", ex_rd, 6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
